// File: rtl/segment_pkg.sv
`default_nettype none
// ============================================================================
// Module      : segment_pkg
// Description : Seven-segment pattern constants (bit0=a .. bit6=g, lit high)
//               and the pattern-to-value decoder shared by the capture logic.
// Revision    : 1.0 - initial release
// ============================================================================
package segment_pkg;

  localparam logic [6:0] c_SEG_BLANK = 7'h00;
  localparam logic [6:0] c_SEG_0     = 7'h3F;
  localparam logic [6:0] c_SEG_1     = 7'h06;
  localparam logic [6:0] c_SEG_2     = 7'h5B;
  localparam logic [6:0] c_SEG_3     = 7'h4F;
  localparam logic [6:0] c_SEG_4     = 7'h66;
  localparam logic [6:0] c_SEG_5     = 7'h6D;
  localparam logic [6:0] c_SEG_6     = 7'h7D;
  localparam logic [6:0] c_SEG_7     = 7'h07;
  localparam logic [6:0] c_SEG_8     = 7'h7F;
  localparam logic [6:0] c_SEG_9     = 7'h6F;
  localparam logic [6:0] c_SEG_A     = 7'h77;
  localparam logic [6:0] c_SEG_B     = 7'h7C;
  localparam logic [6:0] c_SEG_C     = 7'h39;
  localparam logic [6:0] c_SEG_D     = 7'h5E;
  localparam logic [6:0] c_SEG_E     = 7'h79;
  localparam logic [6:0] c_SEG_F     = 7'h71;

  // Returns {err, value}. Unknown patterns (and A-F when hex_en is low)
  // report err=1 with value 0.
  function automatic logic [4:0] segment_to_int(input logic [6:0] seg, input logic hex_en);
    logic [4:0] r;
    r = {1'b1, 4'h0};
    case (seg)
      c_SEG_0: r = {1'b0, 4'h0};
      c_SEG_1: r = {1'b0, 4'h1};
      c_SEG_2: r = {1'b0, 4'h2};
      c_SEG_3: r = {1'b0, 4'h3};
      c_SEG_4: r = {1'b0, 4'h4};
      c_SEG_5: r = {1'b0, 4'h5};
      c_SEG_6: r = {1'b0, 4'h6};
      c_SEG_7: r = {1'b0, 4'h7};
      c_SEG_8: r = {1'b0, 4'h8};
      c_SEG_9: r = {1'b0, 4'h9};
      c_SEG_A: if (hex_en) r = {1'b0, 4'hA};
      c_SEG_B: if (hex_en) r = {1'b0, 4'hB};
      c_SEG_C: if (hex_en) r = {1'b0, 4'hC};
      c_SEG_D: if (hex_en) r = {1'b0, 4'hD};
      c_SEG_E: if (hex_en) r = {1'b0, 4'hE};
      c_SEG_F: if (hex_en) r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segment_stability_filter.sv
`default_nettype none
// ============================================================================
// Module      : segment_stability_filter
// Description : Samples segment/digit-select every cycle, counts consecutive
//               identical valid samples and fires a single capture strobe
//               (with the captured sample) when the run reaches STABLE_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_stability_filter #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            segment_i,
  input  logic [NUM_DIGITS-1:0] sel_i,
  input  logic                  ok_i,
  output logic                  cap_o,
  output logic [6:0]            cap_seg_o,
  output logic [NUM_DIGITS-1:0] cap_sel_o
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [7:0]            cnt_q;
  logic [7:0]            cnt_d;
  logic                  cap_d;
  logic                  cap_q;
  logic [6:0]            cap_seg_q;
  logic [NUM_DIGITS-1:0] cap_sel_q;

  // Run-length of identical valid samples; invalid samples pin the count at 0.
  always_comb begin
    cnt_d = 8'd0;
    if (ok_i) begin
      if ((cnt_q != 8'd0) && (segment_i == seg_q) && (sel_i == sel_q)) begin
        cnt_d = (cnt_q == c_STABLE) ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_d = 8'd1;
      end
    end
    cap_d = (cnt_d == c_STABLE) && (cnt_q != c_STABLE);
  end

  // Sample register, counter and one-shot capture strobe with its payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      cap_q     <= 1'b0;
      cap_seg_q <= '0;
      cap_sel_q <= '0;
    end else begin
      seg_q <= segment_i;
      sel_q <= sel_i;
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      if (cap_d) begin
        cap_seg_q <= segment_i;
        cap_sel_q <= sel_i;
      end
    end
  end

  assign cap_o     = cap_q;
  assign cap_seg_o = cap_seg_q;
  assign cap_sel_o = cap_sel_q;

endmodule
`default_nettype wire

// File: rtl/segment_decoder_capture.sv
`default_nettype none
// ============================================================================
// Module      : segment_decoder_capture
// Description : Observes a multiplexed seven-segment display, decodes stable
//               patterns per digit and emits change events on a valid/ready
//               stream with a sticky overflow flag for dropped events.
//               Define SEGMENT_DECODER_HEX_EN to also accept A-F patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_decoder_capture
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [6:0]                                      segment,
  input  logic [NUM_DIGITS-1:0]                           digit_sel,
  output logic [4*NUM_DIGITS-1:0]                         digit_value,
  output logic [NUM_DIGITS-1:0]                           digit_known,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] out_digit,
  output logic [3:0]                                      out_value,
  output logic                                            out_err,
  output logic                                            overflow
);

  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef SEGMENT_DECODER_HEX_EN
  localparam logic c_HEX_EN = 1'b1;
`else
  localparam logic c_HEX_EN = 1'b0;
`endif

  logic                  w_onehot;
  logic                  w_ok;
  logic                  w_cap;
  logic [6:0]            w_cap_seg;
  logic [NUM_DIGITS-1:0] w_cap_sel;
  logic [c_IDX_W-1:0]    w_idx;
  logic [4:0]            w_dec;
  logic                  w_err;
  logic [3:0]            w_val;
  logic                  w_event;

  logic [4*NUM_DIGITS-1:0] digit_value_q;
  logic [NUM_DIGITS-1:0]   digit_known_q;
  logic                    out_valid_q;
  logic [c_IDX_W-1:0]      out_digit_q;
  logic [3:0]              out_value_q;
  logic                    out_err_q;
  logic                    overflow_q;

  // Qualify raw inputs: exactly one digit enabled and a non-blank pattern.
  always_comb begin
    w_onehot = (digit_sel != '0) && ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
    w_ok     = w_onehot && (segment != c_SEG_BLANK);
  end

  segment_stability_filter #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .segment_i (segment),
    .sel_i     (digit_sel),
    .ok_i      (w_ok),
    .cap_o     (w_cap),
    .cap_seg_o (w_cap_seg),
    .cap_sel_o (w_cap_sel)
  );

  // Encode the captured one-hot select and decide whether the capture is news.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_cap_sel[i]) w_idx = w_idx | c_IDX_W'(i);
    end
    w_dec   = segment_to_int(w_cap_seg, c_HEX_EN);
    w_err   = w_dec[4];
    w_val   = w_dec[3:0];
    w_event = w_cap && (!digit_known_q[w_idx] ||
                        (digit_value_q[4*int'(w_idx) +: 4] != w_val) || w_err);
  end

  // Per-digit state and the single-entry event output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_value_q <= '0;
      digit_known_q <= '0;
      out_valid_q   <= 1'b0;
      out_digit_q   <= '0;
      out_value_q   <= '0;
      out_err_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (w_cap && !w_err) begin
        digit_value_q[4*int'(w_idx) +: 4] <= w_val;
        digit_known_q[w_idx]              <= 1'b1;
      end
      if (out_valid_q && !out_ready) begin
        if (w_event) overflow_q <= 1'b1;
      end else if (w_event) begin
        out_valid_q <= 1'b1;
        out_digit_q <= w_idx;
        out_value_q <= w_val;
        out_err_q   <= w_err;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign digit_value = digit_value_q;
  assign digit_known = digit_known_q;
  assign out_valid   = out_valid_q;
  assign out_digit   = out_digit_q;
  assign out_value   = out_value_q;
  assign out_err     = out_err_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_decoder_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_segment_decoder_capture
// Description : Directed and randomized stimulus against a cycle-level
//               reference model of the segment decoder capture block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_decoder_capture;

  localparam int NUM_DIGITS    = 4;
  localparam int STABLE_CYCLES = 4;
`ifdef SEGMENT_DECODER_HEX_EN
  localparam int c_NPAT = 16;
`else
  localparam int c_NPAT = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  segment = '0;
  logic [3:0]  digit_sel = '0;
  logic [15:0] digit_value;
  logic [3:0]  digit_known;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_digit;
  logic [3:0]  out_value;
  logic        out_err;
  logic        overflow;

  always #5 clk = ~clk;

  segment_decoder_capture #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .segment     (segment),
    .digit_sel   (digit_sel),
    .digit_value (digit_value),
    .digit_known (digit_known),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digit   (out_digit),
    .out_value   (out_value),
    .out_err     (out_err),
    .overflow    (overflow)
  );

  // Reference model state
  typedef struct packed {
    logic       ok;
    logic [6:0] seg;
    logic [3:0] sel;
  } samp_t;

  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  samp_t      hist[$];
  logic       m_pend;
  samp_t      m_psamp;
  logic [3:0] m_dv [4];
  logic [3:0] m_known;
  logic       m_valid;
  logic [1:0] m_digit;
  logic [3:0] m_value;
  logic       m_err;
  logic       m_ovf;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < c_NPAT; k++) begin
      if (pat_tab[k] == s) return {1'b0, 4'(k)};
    end
    return 5'h10;
  endfunction

  function automatic logic [15:0] m_dv_packed();
    return {m_dv[3], m_dv[2], m_dv[1], m_dv[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    m_pend  = 1'b0;
    m_psamp = '0;
    for (int k = 0; k < 4; k++) m_dv[k] = 4'h0;
    m_known = '0;
    m_valid = 1'b0;
    m_digit = '0;
    m_value = '0;
    m_err   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Model one rising edge: resolve last edge's capture, then log this sample.
  task automatic model_edge(input logic [6:0] seg, input logic [3:0] sel,
                            input logic rdy, input logic rst_in);
    logic [4:0] dec;
    logic       ev;
    int         idx;
    int         run;
    samp_t      s;
    if (rst_in) begin
      model_clear();
      return;
    end
    ev  = 1'b0;
    idx = 0;
    dec = '0;
    if (m_pend) begin
      for (int k = 0; k < 4; k++) if (m_psamp.sel[k]) idx = k;
      dec = ref_decode(m_psamp.seg);
      ev  = !m_known[idx] || (m_dv[idx] != dec[3:0]) || dec[4];
      if (!dec[4]) begin
        m_dv[idx]    = dec[3:0];
        m_known[idx] = 1'b1;
      end
    end
    if (m_valid && !rdy) begin
      if (ev) m_ovf = 1'b1;
    end else if (ev) begin
      m_valid = 1'b1;
      m_digit = 2'(idx);
      m_value = dec[3:0];
      m_err   = dec[4];
    end else begin
      m_valid = 1'b0;
    end
    s.ok  = (sel != 4'b0) && ($countones(sel) == 1) && (seg != 7'h00);
    s.seg = seg;
    s.sel = sel;
    hist.push_back(s);
    while (hist.size() > STABLE_CYCLES + 1) void'(hist.pop_front());
    run = 0;
    for (int j = hist.size() - 1; j >= 0; j--) begin
      if (hist[j].ok && (hist[j] == hist[hist.size()-1])) run++;
      else break;
    end
    m_pend  = (run == STABLE_CYCLES);
    m_psamp = s;
  endtask

  // Drive inputs, clock one edge, advance the model and compare.
  task automatic step(input logic [6:0] seg, input logic [3:0] sel,
                      input logic rdy, input logic rst_in);
    segment   = seg;
    digit_sel = sel;
    out_ready = rdy;
    reset     = rst_in;
    if (out_valid && rdy && !rst_in) n_acc++;
    @(posedge clk);
    model_edge(seg, sel, rdy, rst_in);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("digit_value", 32'(digit_value), 32'(m_dv_packed()));
    check("digit_known", 32'(digit_known), 32'(m_known));
    if (m_valid) check("out_payload", 32'({out_digit, out_value, out_err}),
                       32'({m_digit, m_value, m_err}));
  endtask

  task automatic do_reset();
    step(7'h00, 4'b0000, 1'b0, 1'b1);
    check("reset_outputs", 32'({out_valid, out_digit, out_value, out_err, overflow,
                                digit_known, digit_value}), 32'h0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // Single stable digit, ready high: one event after STABLE_CYCLES edges.
    n_acc = 0;
    for (int i = 1; i <= 10; i++) begin
      step(7'h4F, 4'b0001, 1'b1, 1'b0);
      check("lat_valid", 32'(out_valid), 32'(i == STABLE_CYCLES + 1));
    end
    step(7'h00, 4'b0001, 1'b1, 1'b0);
    check("single_events", 32'(n_acc), 32'd1);
    check("single_known", 32'(digit_known), 32'b0001);

    // Held too briefly: nothing captured.
    do_reset();
    for (int i = 0; i < 3; i++) step(7'h4F, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(7'h00, 4'b0001, 1'b1, 1'b0);
      check("short_novalid", 32'(out_valid), 32'd0);
    end
    check("short_known", 32'(digit_known), 32'd0);

    // Three scan rounds: only the first round produces events.
    do_reset();
    n_acc = 0;
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 5; c++) step(pat_tab[d+1], 4'(1 << d), 1'b1, 1'b0);
      end
    end
    step(7'h00, 4'b0000, 1'b1, 1'b0);
    step(7'h00, 4'b0000, 1'b1, 1'b0);
    check("scan_events", 32'(n_acc), 32'd4);
    check("scan_value", 32'(digit_value), 32'h4321);

    // Hex pattern on digit 2 with the consumer stalled.
    do_reset();
    for (int i = 0; i < 6; i++) step(7'h77, 4'b0100, 1'b0, 1'b0);
    check("hex_valid", 32'(out_valid), 32'd1);
`ifdef SEGMENT_DECODER_HEX_EN
    check("hex_payload", 32'({out_value, out_err}), 32'({4'hA, 1'b0}));
    check("hex_known2", 32'(digit_known[2]), 32'd1);
`else
    check("hex_payload", 32'({out_value, out_err}), 32'({4'h0, 1'b1}));
    check("hex_known2", 32'(digit_known[2]), 32'd0);
`endif

    // Two events with the consumer stalled: second is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) step(7'h06, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(7'h5B, 4'b0010, 1'b0, 1'b0);
    step(7'h00, 4'b0000, 1'b0, 1'b0);
    check("ovf_head", 32'({out_valid, out_digit, out_value}), 32'({1'b1, 2'd0, 4'd1}));
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_values", 32'(digit_value[7:0]), 32'h21);
    check("ovf_known", 32'(digit_known), 32'b0011);

    // Reset in the middle of a stable run restarts the count.
    do_reset();
    step(7'h7F, 4'b0001, 1'b1, 1'b0);
    step(7'h7F, 4'b0001, 1'b1, 1'b0);
    step(7'h7F, 4'b0001, 1'b1, 1'b1);
    check("midrst_outputs", 32'({out_valid, overflow, digit_known, digit_value}), 32'h0);
    for (int i = 1; i <= 7; i++) begin
      step(7'h7F, 4'b0001, 1'b1, 1'b0);
      check("midrst_valid", 32'(out_valid), 32'(i == STABLE_CYCLES + 1));
    end

    // Randomized segments of held patterns against the model.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      logic [6:0] seg;
      logic [3:0] sel;
      int         hold;
      int         pick;
      pick = $urandom_range(0, 9);
      if (pick <= 5)      seg = pat_tab[$urandom_range(0, 15)];
      else if (pick == 6) seg = 7'h00;
      else if (pick == 7) seg = 7'($urandom);
      else                seg = pat_tab[$urandom_range(0, 3)];
      pick = $urandom_range(0, 9);
      if (pick == 0)      sel = 4'b0000;
      else if (pick == 1) sel = 4'b0110;
      else                sel = 4'(1 << $urandom_range(0, 3));
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 39) == 0) do_reset();
      for (int h = 0; h < hold; h++) begin
        step(seg, sel, ($urandom_range(0, 9) < 7), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segment_decoder_capture.md
SEGMENT_DECODER_CAPTURE -- requirements
Module: segment_decoder_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits observed.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples required before capture (legal 2..255).
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port segment  input  7  observed pattern: bit0=a through bit6=g, active-high lit, same encoding as the segment_pkg encoders.
REQ-006 SHALL have port digit_sel  input  NUM_DIGITS  active-high digit enable, expected one-hot.
REQ-007 SHALL have port digit_value  output  4*NUM_DIGITS  last decoded value per digit; digit i occupies bits [4i+3:4i].
REQ-008 SHALL have port digit_known  output  NUM_DIGITS  bit i set once digit i has a valid capture.
REQ-009 SHALL have port out_valid  input/output pair: out_valid output 1, out_ready input 1, change-event handshake.
REQ-010 SHALL have ports out_digit  output  $clog2(NUM_DIGITS) (min 1)  digit index; out_value  output  4  decoded value; out_err  output  1  undecodable pattern.
REQ-011 SHALL have port overflow  output  1  sticky: an event was dropped.

Function
REQ-012 SHALL register segment and digit_sel into a sample register every cycle.
REQ-013 SHALL count consecutive cycles where the sample equals the previous sample; any difference resets the count to 1.
REQ-014 SHALL capture once when the count reaches STABLE_CYCLES; count saturates; no recapture until the sample changes.
REQ-015 SHALL ignore (no capture, count held at 0) samples with digit_sel zero or not one-hot, and samples with segment == 7'h00 (blank).
REQ-016 SHALL decode 0-9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); any other non-blank pattern is an error, out_value 4'h0, out_err 1.
REQ-017 On capture without error, SHALL update digit_value[i] and set digit_known[i]; on error, SHALL leave digit_value[i] and digit_known[i] unchanged.
REQ-018 SHALL generate an event only if digit_known[i] is clear, the decoded value differs from digit_value[i], or out_err is 1.
REQ-019 Latency: pattern presented at edge N and held SHALL produce out_valid high after edge N+STABLE_CYCLES.
REQ-020 out_valid SHALL stay high with out_digit/out_value/out_err stable until a cycle with out_ready high; it drops the next cycle unless a new event loads the same edge.
REQ-021 An event arriving while out_valid=1 and out_ready=0 SHALL be dropped from the stream and set overflow; digit registers still update.
REQ-022 An event arriving in the same cycle out_ready accepts the current one SHALL be loaded with no gap and no overflow.

Reset
REQ-023 On reset SHALL clear: sample register, count, digit_value, digit_known, out_valid, out_digit, out_value, out_err, overflow.
REQ-024 Reset mid-stability SHALL discard the partial count; capture restarts from the first post-reset sample.

Configuration
REQ-025 With SEGMENT_DECODER_HEX_EN defined, SHALL additionally decode A-F as 77,7C,39,5E,79,71 (hex) without error.
REQ-026 Without SEGMENT_DECODER_HEX_EN, those six patterns SHALL be errors per REQ-016.

Structure
REQ-027 segment_pkg SHALL hold the pattern constants and a segment_to_int function returning {err, value[3:0]}, taking a hex-enable argument.
REQ-028 Stability detection SHALL live in sub-module segment_stability_filter (sample register, counter, single-shot capture strobe).
REQ-029 One-hot check and digit index encoding SHALL stay in the top module.

Verification
REQ-030 digit_sel=4'b0001, segment=7'h4F held 10 cycles, out_ready=1 -> one event: out_digit 0, out_value 3, out_err 0, 4 cycles after first presentation; digit_known=4'b0001.
REQ-031 Same pattern held only 3 cycles then changed -> no event; digit_known unchanged.
REQ-032 Scan digits 0..3 with 7'h06,7'h5B,7'h4F,7'h66, 5 cycles each, 3 full rounds -> exactly 4 events (values 1,2,3,4), digit_value=16'h4321.
REQ-033 segment=7'h77 on digit 2 -> with SEGMENT_DECODER_HEX_EN: out_value 4'hA, out_err 0; without: out_err 1, digit_known[2] stays 0.
REQ-034 out_ready=0, two events on digits 0 and 1 -> first held on outputs, overflow=1, digit_value updated for both.
REQ-035 Assert reset for one cycle at count 2 of a stable 7'h7F -> all outputs 0; event appears STABLE_CYCLES cycles after reset release.
